demux_1an_param: RTL and testbench

//  Parametrised 1-to-N byte un-striping demux for the L2 receive path; next generation of the 1-to-2 demux.

---
 rtl/demux_1an_param_pkg.sv | 11 +
 rtl/demux_rr_ptr.sv | 27 ++
 rtl/demux_1an_param.sv | 75 +++++++
 tb/tb_demux_1an_param.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/demux_1an_param_pkg.sv
// Shared definitions for the 1-to-N un-striping demux and its matching mux.
package demux_1an_param_pkg;

  localparam logic MODE_RR  = 1'b0;
  localparam logic MODE_SEL = 1'b1;

  function automatic logic sel_legal(input int sel, input int n_out);
    return sel < n_out;
  endfunction

endpackage

// File: rtl/demux_rr_ptr.sv
// Round-robin lane pointer with explicit wrap, sync realignment and reset priority.
module demux_rr_ptr #(
  parameter  int N_OUT = 4,
  localparam int SEL_W = $clog2(N_OUT)
) (
  input  logic             clk_4f,
  input  logic             reset,
  input  logic             adv,
  input  logic             sync,
  output logic [SEL_W-1:0] ptr
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_OUT - 1);
  localparam logic [SEL_W-1:0] ONE  = SEL_W'(1);

  // Explicit wrap: N_OUT need not be a power of two.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      ptr <= '0;
    end else if (sync) begin
      ptr <= adv ? ONE : '0;
    end else if (adv) begin
      ptr <= (ptr == LAST) ? '0 : ptr + ONE;
    end
  end

endmodule

// File: rtl/demux_1an_param.sv
// Parametrised 1-to-N byte un-striping demux: round-robin or explicit lane select,
// registered lane outputs, pointer status and illegal-select error pulse.
module demux_1an_param
  import demux_1an_param_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int N_OUT  = 4,
  localparam int SEL_W  = $clog2(N_OUT)
) (
  input  logic                    clk_4f,
  input  logic                    reset,
  input  logic                    valid,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel_in,
  input  logic                    sync,
  output logic [N_OUT-1:0]        validout,
  output logic [N_OUT*DATA_W-1:0] dataout,
  output logic [SEL_W-1:0]        sel_ptr,
  output logic                    err_sel
);

  logic [SEL_W-1:0]        ptr;
  logic [SEL_W-1:0]        target;
  logic                    legal;
  logic                    wr;
  logic [N_OUT-1:0]        hit;
  logic [N_OUT-1:0]        vld_p1;
  logic [N_OUT*DATA_W-1:0] data_p1;
  logic                    err_p1;

  demux_rr_ptr #(.N_OUT(N_OUT)) u_ptr (
    .clk_4f (clk_4f),
    .reset  (reset),
    .adv    (valid & (mode == MODE_RR)),
    .sync   (sync),
    .ptr    (ptr)
  );

  // Lane decode; sync in round-robin forces the word onto lane 0.
  always_comb begin
    target = sel_in;
    legal  = sel_legal(int'(sel_in), N_OUT);
    if (mode == MODE_RR) begin
      target = sync ? '0 : ptr;
      legal  = 1'b1;
    end
    wr  = valid & legal;
    hit = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (wr && (int'(target) == k)) hit[k] = 1'b1;
    end
  end

  // Stage p1: registered lanes, one-cycle valid and error pulses.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      vld_p1  <= '0;
      data_p1 <= '0;
      err_p1  <= 1'b0;
    end else begin
      vld_p1 <= hit;
      err_p1 <= valid & ~legal;
      for (int k = 0; k < N_OUT; k++) begin
        if (hit[k]) data_p1[k*DATA_W +: DATA_W] <= data_in;
      end
    end
  end

  assign validout = vld_p1;
  assign dataout  = data_p1;
  assign err_sel  = err_p1;
  assign sel_ptr  = ptr;

endmodule

// File: tb/tb_demux_1an_param.sv
// Scoreboard bench: two demux instances (N_OUT=4 and N_OUT=3) driven in parallel
// and compared every cycle against a lane-array reference model.
module tb_demux_1an_param;

  logic        clk = 1'b0;
  logic        reset, valid, mode, sync;
  logic [7:0]  data_in;
  logic [1:0]  sel_in;
  logic [3:0]  vo4;
  logic [31:0] do4;
  logic [1:0]  sp4;
  logic        er4;
  logic [2:0]  vo3;
  logic [23:0] do3;
  logic [1:0]  sp3;
  logic        er3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] data;
    logic [1:0]  ptr;
    logic        err;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];
  int         m_ptr[2];
  logic [7:0] m_lane[2][4];

  always #5 clk = ~clk;

  demux_1an_param #(.DATA_W(8), .N_OUT(4)) u4 (
    .clk_4f(clk), .reset(reset), .valid(valid), .data_in(data_in), .mode(mode),
    .sel_in(sel_in), .sync(sync), .validout(vo4), .dataout(do4), .sel_ptr(sp4), .err_sel(er4)
  );

  demux_1an_param #(.DATA_W(8), .N_OUT(3)) u3 (
    .clk_4f(clk), .reset(reset), .valid(valid), .data_in(data_in), .mode(mode),
    .sel_in(sel_in), .sync(sync), .validout(vo3), .dataout(do3), .sel_ptr(sp3), .err_sel(er3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: lanes as a plain array, pointer as an integer modulo n.
  task automatic model(input int id, input int n, input logic r, input logic v,
                       input logic [7:0] d, input logic m, input int s, input logic sy,
                       output exp_t e);
    int tgt;
    e.vld = '0;
    e.err = 1'b0;
    tgt   = -1;
    if (r) begin
      m_ptr[id] = 0;
      for (int k = 0; k < 4; k++) m_lane[id][k] = 8'h00;
    end else if (v) begin
      if (m == 1'b0) begin
        tgt       = sy ? 0 : m_ptr[id];
        m_ptr[id] = sy ? 1 : (m_ptr[id] + 1) % n;
      end else begin
        if (s < n) tgt = s;
        else       e.err = 1'b1;
        if (sy) m_ptr[id] = 0;
      end
    end else if (sy) begin
      m_ptr[id] = 0;
    end
    if (tgt >= 0) begin
      m_lane[id][tgt] = d;
      e.vld[tgt]      = 1'b1;
    end
    e.ptr = m_ptr[id][1:0];
    for (int k = 0; k < 4; k++) e.data[k*8 +: 8] = m_lane[id][k];
  endtask

  // Drive at the current negedge, record expectations, then wait for the next negedge.
  task automatic step(input logic r, input logic v, input logic [7:0] d,
                      input logic m, input logic [1:0] s, input logic sy);
    exp_t e4, e3;
    reset = r; valid = v; data_in = d; mode = m; sel_in = s; sync = sy;
    model(0, 4, r, v, d, m, int'(s), sy, e4);
    model(1, 3, r, v, d, m, int'(s), sy, e3);
    q4.push_back(e4);
    q3.push_back(e3);
    @(negedge clk);
  endtask

  // Monitor: compares every registered output shortly after each active edge.
  always @(posedge clk) begin
    exp_t e4, e3;
    #1;
    if (q4.size() > 0) begin
      e4 = q4.pop_front();
      check("u4_validout", 32'(vo4), 32'(e4.vld));
      check("u4_dataout", do4, e4.data);
      check("u4_sel_ptr", 32'(sp4), 32'(e4.ptr));
      check("u4_err_sel", 32'(er4), 32'(e4.err));
      check("u4_onehot", 32'($countones(vo4) <= 1), 32'd1);
    end
    if (q3.size() > 0) begin
      e3 = q3.pop_front();
      check("u3_validout", 32'(vo3), 32'(e3.vld));
      check("u3_dataout", 32'(do3), 32'(e3.data[23:0]));
      check("u3_sel_ptr", 32'(sp3), 32'(e3.ptr));
      check("u3_err_sel", 32'(er3), 32'(e3.err));
      check("u3_onehot", 32'($countones(vo3) <= 1), 32'd1);
    end
  end

  initial begin
    reset = 1'b1; valid = 1'b0; data_in = '0; mode = 1'b0; sel_in = '0; sync = 1'b0;
    m_ptr[0] = 0; m_ptr[1] = 0;
    for (int k = 0; k < 4; k++) begin m_lane[0][k] = 8'h00; m_lane[1][k] = 8'h00; end
    @(negedge clk);

    // 1: reset two cycles, then six round-robin words
    step(1, 0, 8'h00, 0, 0, 0);
    check("t1_reset_vld", 32'(vo4), 32'd0);
    check("t1_reset_ptr", 32'(sp4), 32'd0);
    step(1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 8'hA0 + 8'(i), 0, 0, 0);
    check("t1_lane0", 32'(do4[7:0]), 32'hA4);
    check("t1_lane1", 32'(do4[15:8]), 32'hA5);
    check("t1_lane2", 32'(do4[23:16]), 32'hA2);
    check("t1_lane3", 32'(do4[31:24]), 32'hA3);
    check("t1_ptr", 32'(sp4), 32'd2);

    // 2: valid pattern 1,0,1,0 from lane 0
    step(0, 0, 8'h00, 0, 0, 1);
    step(0, 1, 8'h11, 0, 0, 0);
    step(0, 0, 8'($urandom), 0, 0, 0);
    check("t2_idle_vld", 32'(vo4), 32'd0);
    step(0, 1, 8'h22, 0, 0, 0);
    check("t2_lane1_vld", 32'(vo4), 32'b0010);
    step(0, 0, 8'($urandom), 0, 0, 0);
    check("t2_lane0_hold", 32'(do4[7:0]), 32'h11);
    check("t2_lane1", 32'(do4[15:8]), 32'h22);

    // 3: sync together with a word while the pointer sits at 2
    step(0, 0, 8'h00, 0, 0, 1);
    step(0, 1, 8'h31, 0, 0, 0);
    step(0, 1, 8'h32, 0, 0, 0);
    step(0, 1, 8'h55, 0, 0, 1);
    check("t3_lane0", 32'(do4[7:0]), 32'h55);
    check("t3_ptr", 32'(sp4), 32'd1);
    step(0, 1, 8'h66, 0, 0, 0);
    check("t3_lane1", 32'(do4[15:8]), 32'h66);

    // 4: explicit select, then an out-of-range select on the 3-lane instance
    step(0, 1, 8'h77, 1, 2'd2, 0);
    check("t4_u3_lane2", 32'(do3[23:16]), 32'h77);
    step(0, 1, 8'h88, 1, 2'd3, 0);
    check("t4_u3_err", 32'(er3), 32'd1);
    check("t4_u3_vld", 32'(vo3), 32'd0);
    check("t4_u3_ptr", 32'(sp3), 32'd2);
    check("t4_u3_lane2_hold", 32'(do3[23:16]), 32'h77);
    step(0, 0, 8'h00, 1, 2'd0, 0);
    check("t4_u3_err_pulse", 32'(er3), 32'd0);

    // 5: reset mid-stream discards the in-flight word
    step(0, 1, 8'h44, 0, 0, 0);
    step(1, 1, 8'h99, 0, 0, 0);
    check("t5_vld", 32'(vo4), 32'd0);
    check("t5_data", do4, 32'd0);
    check("t5_ptr", 32'(sp4), 32'd0);

    // 6: random traffic in both modes with sync and reset
    for (int i = 0; i < 1000; i++) begin
      step(logic'($urandom_range(0, 49) == 0), logic'($urandom_range(0, 9) < 7),
           8'($urandom), logic'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           logic'($urandom_range(0, 7) == 0));
    end
    step(0, 0, 8'h00, 0, 0, 0);

    for (int i = 0; i < 5 && (q4.size() + q3.size()) > 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(q4.size() + q3.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
